// File: rtl/stack_pointer_unit_pkg.sv
// Shared types for the stack pointer unit: FSM state encoding, fault codes
// and the range check used when the SP is loaded.
package stack_pointer_unit_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAULT   = 2'd3
  } sp_state_e;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

  // True when v lies inside the inclusive window [lo, hi].
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ten_bit_decrementer.sv
// 10-bit decrement-by-one built as a half-subtractor borrow chain.
module ten_bit_decrementer (
  input  logic [9:0] i_a,
  output logic [9:0] o_s,
  output logic       o_o
);

  logic w_borrow;

  // Ripple a borrow of one from bit 0 upward; o_o is the final borrow.
  always_comb begin
    w_borrow = 1'b1;
    o_s      = '0;
    for (int i = 0; i < 10; i++) begin
      o_s[i]   = i_a[i] ^ w_borrow;
      w_borrow = ~i_a[i] & w_borrow;
    end
    o_o = w_borrow;
  end

endmodule

// File: rtl/ten_bit_incrementer.sv
// 10-bit increment-by-one built as a half-adder carry chain.
module ten_bit_incrementer (
  input  logic [9:0] i_a,
  output logic [9:0] o_s,
  output logic       o_o
);

  logic w_carry;

  // Ripple a carry of one from bit 0 upward; o_o is the final carry.
  always_comb begin
    w_carry = 1'b1;
    o_s     = '0;
    for (int i = 0; i < 10; i++) begin
      o_s[i]  = i_a[i] ^ w_carry;
      w_carry = i_a[i] & w_carry;
    end
    o_o = w_carry;
  end

endmodule

// File: rtl/stack_pointer_unit.sv
// Stack pointer owner for a downward-growing stack: generates the stack
// memory address/strobes for push and pop, tracks empty/full and latches
// overflow, underflow and illegal-command faults.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_EMPTY   | sp == STACK_TOP, nothing stored, sp is next free slot
//   ST_PARTIAL | at least one entry stored, sp is next free slot
//   ST_FULL    | sp == STACK_LIMIT and that slot is occupied
//   ST_FAULT   | commands ignored until clear_fault; sp and code held
module stack_pointer_unit
  import stack_pointer_unit_pkg::*;
#(
  parameter logic [9:0] STACK_TOP   = 10'h3FF,
  parameter logic [9:0] STACK_LIMIT = 10'h300
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_sp_load,
  input  logic [9:0] i_sp_load_val,
  input  logic       i_clear_fault,
  output logic [9:0] o_sp,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_fault,
  output logic [1:0] o_fault_code,
  output logic [9:0] o_mem_addr,
  output logic       o_mem_we,
  output logic       o_mem_re
);

  sp_state_e  r_state;
  logic [9:0] r_sp;
  logic [1:0] r_fault_code;
  logic       r_empty;
  logic       r_full;
  logic       r_fault;

  sp_state_e  w_nxt_state;
  logic [9:0] w_nxt_sp;
  logic [1:0] w_nxt_fc;
  logic [9:0] w_sp_dec;
  logic [9:0] w_sp_inc;
  logic       w_dec_o;
  logic       w_inc_o;
  logic       w_unused_carry;

  ten_bit_decrementer u_dec (.i_a(r_sp), .o_s(w_sp_dec), .o_o(w_dec_o));
  ten_bit_incrementer u_inc (.i_a(r_sp), .o_s(w_sp_inc), .o_o(w_inc_o));

  // Range checks always precede the SP update, so the chain carries never matter.
  assign w_unused_carry = w_dec_o ^ w_inc_o;

  // Command decode: picks next SP/state/code and this cycle's memory strobes.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sp    = r_sp;
    w_nxt_fc    = r_fault_code;
    o_mem_addr  = r_sp;
    o_mem_we    = 1'b0;
    o_mem_re    = 1'b0;
    if (i_reset) begin
      // in-flight op discarded; registers reload in the sequential block
    end else if (r_state == ST_FAULT) begin
      if (i_clear_fault) begin
        w_nxt_fc    = FC_NONE;
        w_nxt_state = (r_sp == STACK_TOP) ? ST_EMPTY : ST_PARTIAL;
      end
    end else if (i_sp_load) begin
      if (in_range(i_sp_load_val, STACK_LIMIT, STACK_TOP)) begin
        w_nxt_sp    = i_sp_load_val;
        w_nxt_state = (i_sp_load_val == STACK_TOP) ? ST_EMPTY : ST_PARTIAL;
      end else begin
        w_nxt_fc    = FC_ILLEGAL;
        w_nxt_state = ST_FAULT;
      end
    end else if (i_push && i_pop) begin
      w_nxt_fc    = FC_ILLEGAL;
      w_nxt_state = ST_FAULT;
    end else if (i_push) begin
      if (r_state == ST_FULL) begin
        w_nxt_fc    = FC_OVERFLOW;
        w_nxt_state = ST_FAULT;
      end else begin
        o_mem_we = 1'b1;
        if (r_sp == STACK_LIMIT) begin
          w_nxt_state = ST_FULL;
        end else begin
          w_nxt_sp    = w_sp_dec;
          w_nxt_state = ST_PARTIAL;
        end
      end
    end else if (i_pop) begin
      if (r_state == ST_EMPTY) begin
        w_nxt_fc    = FC_UNDERFLOW;
        w_nxt_state = ST_FAULT;
      end else if (r_state == ST_FULL) begin
        // the limit slot itself holds data, so read it in place
        o_mem_re    = 1'b1;
        w_nxt_state = (STACK_LIMIT == STACK_TOP) ? ST_EMPTY : ST_PARTIAL;
      end else begin
        o_mem_addr  = w_sp_inc;
        o_mem_re    = 1'b1;
        w_nxt_sp    = w_sp_inc;
        w_nxt_state = (w_sp_inc == STACK_TOP) ? ST_EMPTY : ST_PARTIAL;
      end
    end
  end

  // State, SP, fault code and decoded status flags update on the clock edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_EMPTY;
      r_sp         <= STACK_TOP;
      r_fault_code <= FC_NONE;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_sp         <= w_nxt_sp;
      r_fault_code <= w_nxt_fc;
      r_empty      <= (w_nxt_state == ST_EMPTY);
      r_full       <= (w_nxt_state == ST_FULL);
      r_fault      <= (w_nxt_state == ST_FAULT);
    end
  end

  assign o_sp         = r_sp;
  assign o_empty      = r_empty;
  assign o_full       = r_full;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit with a 4-deep stack (3FC..3FF).
module tb_stack_pointer_unit;

  logic       clk = 1'b0;
  logic       reset, push, pop, sp_load, clear_fault;
  logic [9:0] sp_load_val;
  logic [9:0] sp, mem_addr;
  logic [1:0] fault_code;
  logic       empty, full, fault, mem_we, mem_re;

  int n_vec = 0;
  int n_bad = 0;

  stack_pointer_unit #(.STACK_TOP(10'h3FF), .STACK_LIMIT(10'h3FC)) dut (
    .i_clk(clk), .i_reset(reset), .i_push(push), .i_pop(pop),
    .i_sp_load(sp_load), .i_sp_load_val(sp_load_val), .i_clear_fault(clear_fault),
    .o_sp(sp), .o_empty(empty), .o_full(full), .o_fault(fault),
    .o_fault_code(fault_code), .o_mem_addr(mem_addr),
    .o_mem_we(mem_we), .o_mem_re(mem_re)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic p, input logic q, input logic l,
                       input logic [9:0] v, input logic c);
    push = p; pop = q; sp_load = l; sp_load_val = v; clear_fault = c;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next_cycle();
    reset = 1'b0;
  endtask

  logic [9:0] push_addr [4];
  logic [9:0] pop_addr  [4];
  logic [9:0] pop_sp    [4];

  initial begin
    push_addr = '{10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC};
    pop_addr  = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF};
    pop_sp    = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF};
    reset = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // 1. reset state while idle
    chk ("rst_sp",    sp, 10'h3FF);
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full",  full, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chk ("rst_fc",    {8'b0, fault_code}, 10'h000);
    chk1("rst_we",    mem_we, 1'b0);
    chk1("rst_re",    mem_re, 1'b0);
    chk ("idle_addr", mem_addr, 10'h3FF);

    // 2. fill the stack, then overflow
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
      chk ("push_addr", mem_addr, push_addr[i]);
      chk1("push_we",   mem_we, 1'b1);
      next_cycle();
    end
    idle();
    chk ("full_sp", sp, 10'h3FC);
    chk1("full_flag", full, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    chk1("ovf_we", mem_we, 1'b0);
    next_cycle();
    idle();
    chk1("ovf_fault", fault, 1'b1);
    chk ("ovf_fc", {8'b0, fault_code}, 10'h001);
    chk ("ovf_sp", sp, 10'h3FC);
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    chk1("fault_ignore_we", mem_we, 1'b0);
    next_cycle();
    idle();
    chk ("fault_hold_fc", {8'b0, fault_code}, 10'h001);

    // 3. refill, drain from FULL, then underflow
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
      next_cycle();
    end
    idle();
    chk1("refill_full", full, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
      chk ("pop_addr", mem_addr, pop_addr[i]);
      chk1("pop_re",   mem_re, 1'b1);
      next_cycle();
      idle();
      chk ("pop_sp", sp, pop_sp[i]);
    end
    chk1("drain_empty", empty, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    chk1("unf_re", mem_re, 1'b0);
    chk1("unf_we", mem_we, 1'b0);
    next_cycle();
    idle();
    chk ("unf_fc", {8'b0, fault_code}, 10'h002);
    chk ("unf_sp", sp, 10'h3FF);

    // 4. simultaneous push and pop from PARTIAL, then clear
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    next_cycle();
    idle();
    chk ("pp_pre_sp", sp, 10'h3FE);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    chk1("pp_we", mem_we, 1'b0);
    chk1("pp_re", mem_re, 1'b0);
    next_cycle();
    idle();
    chk ("pp_fc", {8'b0, fault_code}, 10'h003);
    chk ("pp_sp", sp, 10'h3FE);
    drive(1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
    next_cycle();
    idle();
    chk1("clr_fault", fault, 1'b0);
    chk ("clr_fc", {8'b0, fault_code}, 10'h000);
    chk1("clr_empty", empty, 1'b0);
    chk1("clr_full",  full, 1'b0);

    // 5. SP loads: legal, illegal, and load beating push
    drive(1'b0, 1'b0, 1'b1, 10'h3FD, 1'b0);
    next_cycle();
    idle();
    chk ("ld_sp", sp, 10'h3FD);
    chk1("ld_empty", empty, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 10'h2FF, 1'b0);
    next_cycle();
    idle();
    chk ("ld_bad_fc", {8'b0, fault_code}, 10'h003);
    chk ("ld_bad_sp", sp, 10'h3FD);
    drive(1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 10'h3FE, 1'b0);
    chk1("ld_push_we", mem_we, 1'b0);
    next_cycle();
    idle();
    chk ("ld_push_sp", sp, 10'h3FE);
    chk1("ld_push_fault", fault, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 10'h3FF, 1'b0);
    next_cycle();
    idle();
    chk1("ld_top_empty", empty, 1'b1);

    // 6. reset in the same cycle as a push from PARTIAL
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    next_cycle();
    idle();
    chk ("r6_pre_sp", sp, 10'h3FE);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    chk1("r6_we", mem_we, 1'b0);
    next_cycle();
    reset = 1'b0;
    idle();
    chk ("r6_sp", sp, 10'h3FF);
    chk1("r6_empty", empty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
